// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: shared widths, latency and opcode encodings for the ALU scheduler
package alu_sched_pkg;
  localparam int DATA_W = 8;
  localparam int OP_W = 3;
  localparam int ALU_LATENCY = 4;
  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_AND = 3'd2;
  localparam logic [OP_W-1:0] OP_OR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR = 3'd4;
  localparam logic [OP_W-1:0] OP_NOT = 3'd5;
  localparam logic [OP_W-1:0] OP_SHL = 3'd6;
  localparam logic [OP_W-1:0] OP_SHR = 3'd7;
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } alu_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant search starting at a pointer that moves past each winner
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               gnt_valid
);
  logic [ID_W-1:0] ptr;
  logic            hit;
  always_comb begin
    hit = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NUM_REQ]) begin
        hit = 1'b1;
        gnt_idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      end
    end
    gnt_valid = hit & en & ~reset;
    gnt = gnt_valid ? NUM_REQ'(1) << gnt_idx : '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) ptr <= '0;
    else if (gnt_valid) ptr <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
endmodule

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: shares one pipelined ALU among requesters and returns results tagged by requester
module alu_rr_scheduler
  import alu_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ALU_LATENCY = alu_sched_pkg::ALU_LATENCY,
  parameter int ID_W = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [OP_W*NUM_REQ-1:0]   req_op,
  input  logic [DATA_W*NUM_REQ-1:0] req_a,
  input  logic [DATA_W*NUM_REQ-1:0] req_b,
  output logic [OP_W-1:0]           alu_op,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  input  logic [DATA_W-1:0]         alu_result,
  output logic                      resp_valid,
  output logic [ID_W-1:0]           resp_id,
  output logic [DATA_W-1:0]         resp_data,
  output logic [2:0]                inflight
);
  logic [ID_W-1:0]                  gnt_idx;
  logic                             gnt_valid;
  alu_req_t                         iss;
  logic                             iss_v;
  logic [ID_W-1:0]                  iss_id;
  logic [ALU_LATENCY-1:0]           tag_v;
  logic [ALU_LATENCY-1:0][ID_W-1:0] tag_id;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .req       (req_valid),
    .gnt       (req_ready),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );
  // tag stages mirror the ALU stages so the last one lines up with alu_result
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      iss <= '0;
      iss_v <= 1'b0;
      iss_id <= '0;
      tag_v <= '0;
      tag_id <= '0;
      inflight <= '0;
    end else begin
      iss <= gnt_valid ? alu_req_t'{op: req_op[OP_W*gnt_idx +: OP_W],
                                    a:  req_a[DATA_W*gnt_idx +: DATA_W],
                                    b:  req_b[DATA_W*gnt_idx +: DATA_W]} : '0;
      iss_v <= gnt_valid;
      iss_id <= gnt_valid ? gnt_idx : '0;
      tag_v <= {tag_v[ALU_LATENCY-2:0], iss_v};
      tag_id <= {tag_id[ALU_LATENCY-2:0], iss_id};
      inflight <= inflight + {2'b0, gnt_valid} - {2'b0, resp_valid};
    end
  assign alu_op = iss.op;
  assign alu_a = iss.a;
  assign alu_b = iss.b;
  assign resp_valid = tag_v[ALU_LATENCY-1];
  assign resp_id = tag_id[ALU_LATENCY-1];
  assign resp_data = resp_valid ? alu_result : '0;
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb_alu_rr_scheduler: directed checks of arbitration, latency, draining and reset flush
module tb_alu_rr_scheduler;
  import alu_sched_pkg::*;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  req_valid, req_ready;
  logic [11:0] req_op;
  logic [31:0] req_a, req_b;
  logic [2:0]  alu_op;
  logic [7:0]  alu_a, alu_b, alu_result, resp_data;
  logic        resp_valid;
  logic [1:0]  resp_id;
  logic [2:0]  inflight;
  logic [7:0]  st [4];
  logic [7:0]  sums [4];
  logic [1:0]  dr_id [3];
  logic [7:0]  dr_data [3];
  logic        exp_v;
  int passed = 0;
  int total = 0;
  int failed = 0;
  alu_rr_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .inflight   (inflight)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOT:  return ~a;
      OP_SHL:  return {a[6:0], 1'b0};
      default: return {1'b0, a[7:1]};
    endcase
  endfunction
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < 4; i++) st[i] <= '0;
    end else begin
      st[0] <= alu_f(alu_op, alu_a, alu_b);
      for (int i = 1; i < 4; i++) st[i] <= st[i-1];
    end
  assign alu_result = st[3];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  task automatic setreq(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    req_valid[i] = 1'b1;
    req_op[3*i +: 3] = op;
    req_a[8*i +: 8] = a;
    req_b[8*i +: 8] = b;
  endtask
  initial begin
    sums = '{8'h10, 8'h21, 8'h32, 8'h43};
    dr_id = '{2'd2, 2'd3, 2'd0};
    dr_data = '{8'h02, 8'h04, 8'h06};
    req_valid = '0;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    req_valid = 4'hF;
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_alu", {alu_op, alu_a, alu_b}, 0);
    chk("rst_resp", {resp_valid, resp_id}, 0);
    chk("rst_inflight", inflight, 0);
    req_valid = '0;
    reset = 1'b0;
    nxt();
    setreq(0, OP_ADD, 8'h05, 8'h03);
    #1;
    chk("t1_ready", req_ready, 4'b0001);
    nxt();
    req_valid = '0;
    #1;
    chk("t1_alu", {alu_op, alu_a, alu_b}, {3'd0, 8'h05, 8'h03});
    chk("t1_inflight", inflight, 1);
    chk("t1_nores", resp_valid, 0);
    nxt();
    for (int k = 2; k <= 4; k++) begin
      #1;
      chk("t1_wait_res", resp_valid, 0);
      chk("t1_wait_infl", inflight, 1);
      nxt();
    end
    #1;
    chk("t1_resp", {resp_valid, resp_id, resp_data}, {1'b1, 2'd0, 8'h08});
    chk("t1_infl_n5", inflight, 1);
    nxt();
    #1;
    chk("t1_done", {resp_valid, inflight}, 0);
    setreq(0, OP_OR, 8'h10, 8'h01);
    setreq(3, OP_XOR, 8'hAA, 8'h0F);
    #1;
    chk("t4_first", req_ready, 4'b1000);
    nxt();
    req_valid[3] = 1'b0;
    #1;
    chk("t4_second", req_ready, 4'b0001);
    nxt();
    req_valid = '0;
    repeat (3) nxt();
    #1;
    chk("t4_resp3", {resp_valid, resp_id, resp_data}, {1'b1, 2'd3, 8'hA5});
    nxt();
    #1;
    chk("t4_resp0", {resp_valid, resp_id, resp_data}, {1'b1, 2'd0, 8'h11});
    nxt();
    #1;
    chk("t4_idle", inflight, 0);
    setreq(2, OP_SUB, 8'h03, 8'h05);
    #1;
    chk("t3_g2", req_ready, 4'b0100);
    nxt();
    req_valid = '0;
    setreq(1, OP_SHL, 8'h81, 8'h00);
    #1;
    chk("t3_g1", req_ready, 4'b0010);
    nxt();
    req_valid = '0;
    setreq(3, OP_NOT, 8'h0F, 8'h00);
    #1;
    chk("t3_g3", req_ready, 4'b1000);
    nxt();
    req_valid = '0;
    repeat (2) nxt();
    #1;
    chk("t3_sub", {resp_valid, resp_id, resp_data}, {1'b1, 2'd2, 8'hFE});
    nxt();
    #1;
    chk("t3_shl", {resp_valid, resp_id, resp_data}, {1'b1, 2'd1, 8'h02});
    nxt();
    #1;
    chk("t3_not", {resp_valid, resp_id, resp_data}, {1'b1, 2'd3, 8'hF0});
    nxt();
    #1;
    chk("t3_idle", {resp_valid, inflight}, 0);
    for (int i = 0; i < 4; i++) setreq(i, OP_ADD, 8'(8'h10 * (i + 1)), 8'(i));
    for (int g = 0; g < 6; g++) begin
      #1;
      chk("t2_grant", req_ready, 32'(1 << (g % 4)));
      if (g == 4) chk("t2_infl4", inflight, 4);
      if (g == 5) begin
        chk("t2_infl5", inflight, 5);
        chk("t2_resp_first", {resp_valid, resp_id, resp_data}, {1'b1, 2'd0, 8'h10});
      end
      nxt();
    end
    req_valid = '0;
    for (int r = 1; r <= 5; r++) begin
      #1;
      chk("t2_resp", {resp_valid, resp_id, resp_data}, {1'b1, 2'(r % 4), sums[r % 4]});
      if (r == 1) chk("t2_infl_sat", inflight, 5);
      nxt();
    end
    #1;
    chk("t2_idle", {resp_valid, inflight}, 0);
    setreq(2, OP_ADD, 8'h01, 8'h01);
    #1;
    chk("t5_g2", req_ready, 4'b0100);
    nxt();
    req_valid = '0;
    setreq(3, OP_ADD, 8'h02, 8'h02);
    #1;
    chk("t5_g3", req_ready, 4'b1000);
    nxt();
    req_valid = '0;
    setreq(0, OP_ADD, 8'h03, 8'h03);
    #1;
    chk("t5_g0", req_ready, 4'b0001);
    nxt();
    req_valid = '0;
    en = 1'b0;
    setreq(1, OP_AND, 8'hF0, 8'h3C);
    for (int t = 0; t < 8; t++) begin
      #1;
      if (t == 0) chk("t5_infl3", inflight, 3);
      chk("t5_noready", req_ready, 0);
      exp_v = (t >= 2) && (t <= 4);
      chk("t5_rv", resp_valid, exp_v);
      if (exp_v) chk("t5_drain", {resp_id, resp_data}, {dr_id[t-2], dr_data[t-2]});
      if (t >= 1) chk("t5_bubble", {alu_op, alu_a, alu_b}, 0);
      nxt();
    end
    #1;
    chk("t5_empty", inflight, 0);
    en = 1'b1;
    #1;
    chk("t5_regrant", req_ready, 4'b0010);
    nxt();
    req_valid = '0;
    repeat (4) nxt();
    #1;
    chk("t5_resp1", {resp_valid, resp_id, resp_data}, {1'b1, 2'd1, 8'h30});
    nxt();
    setreq(2, OP_ADD, 8'h11, 8'h11);
    nxt();
    req_valid = '0;
    setreq(3, OP_ADD, 8'h22, 8'h22);
    nxt();
    req_valid = '0;
    setreq(0, OP_ADD, 8'h33, 8'h33);
    nxt();
    req_valid = '0;
    #1;
    chk("t6_infl3", inflight, 3);
    reset = 1'b1;
    #1;
    chk("t6_flush", {resp_valid, inflight}, 0);
    chk("t6_alu", {alu_op, alu_a, alu_b}, 0);
    nxt();
    reset = 1'b0;
    for (int t = 0; t < 6; t++) begin
      #1;
      chk("t6_quiet", {resp_valid, inflight}, 0);
      nxt();
    end
    setreq(0, OP_ADD, 8'h07, 8'h08);
    setreq(1, OP_ADD, 8'h09, 8'h09);
    #1;
    chk("t6_ptr0", req_ready, 4'b0001);
    nxt();
    req_valid = '0;
    repeat (4) nxt();
    #1;
    chk("t6_resp", {resp_valid, resp_id, resp_data}, {1'b1, 2'd0, 8'h0F});
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
